// File: rtl/uart_pkg.sv
// Shared definitions for the uart_trx block: FSM encodings and baud timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int uart_div(input int clk_freq, input int uart_freq);
        return clk_freq / uart_freq;
    endfunction

    function automatic int uart_half(input int div);
        return div / 32'sd2;
    endfunction

    function automatic int uart_cnt_width(input int div);
        return $clog2(div + 32'sd1);
    endfunction

endpackage

// File: rtl/uart_trx_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input line.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Resolve metastability over two stages; both stages reset to the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART: independent receive and transmit FSMs sharing one clock.
module uart_trx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_stopbit,
    output logic       rx_frame_err,
    input  logic       tx_write,
    input  logic [7:0] tx_data,
    output logic       tx_finished,
    output logic       tx_busy,
    output logic       dbg_rx_inprogress,
    output logic       dbg_tx_inprogress
);

    localparam int DIV  = uart_div(CLK_FREQ, UART_FREQ);
    localparam int HALF = uart_half(DIV);
    localparam int CW   = uart_cnt_width(DIV);

    // Counters expire at zero, so loading N-1 yields exactly N cycles per interval.
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 32'sd1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 32'sd1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic rx_sync_s;

    sync2 u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync_s)
    );

    rx_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bits_q, rx_bits_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_prev_q;
    logic        rx_ready_q, rx_ready_d;
    logic        rx_stopbit_q, rx_stopbit_d;
    logic        rx_frame_err_q, rx_frame_err_d;
    logic        dbg_rx_q, dbg_rx_d;

    // Receive next-state: mid-bit sampling driven by the down-counter.
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_bits_d      = rx_bits_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_ready_d     = 1'b0;
        rx_stopbit_d   = 1'b0;
        rx_frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LOAD;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    if (!rx_sync_s) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LOAD;
                        rx_bits_d  = 4'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    rx_shift_d = {rx_sync_s, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LOAD;
                    if (rx_bits_q == 4'd7) begin
                        rx_state_d   = RX_STOP;
                        rx_stopbit_d = 1'b1;
                    end else begin
                        rx_bits_d = rx_bits_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_ZERO) begin
                    if (rx_sync_s) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
        dbg_rx_d = (rx_state_d != RX_IDLE);
    end

    // Receive state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= CNT_ZERO;
            rx_bits_q      <= 4'd0;
            rx_shift_q     <= 8'h00;
            rx_data_q      <= 8'h00;
            rx_prev_q      <= 1'b1;
            rx_ready_q     <= 1'b0;
            rx_stopbit_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            dbg_rx_q       <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bits_q      <= rx_bits_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_prev_q      <= rx_sync_s;
            rx_ready_q     <= rx_ready_d;
            rx_stopbit_q   <= rx_stopbit_d;
            rx_frame_err_q <= rx_frame_err_d;
            dbg_rx_q       <= dbg_rx_d;
        end
    end

    tx_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_finished_q, tx_finished_d;
    logic        dbg_tx_q, dbg_tx_d;

    // Transmit next-state; finished/busy are set one cycle early so they land in the last stop cycle.
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q;
        tx_bits_d     = tx_bits_q;
        tx_shift_d    = tx_shift_q;
        tx_d          = tx_q;
        tx_busy_d     = tx_busy_q;
        tx_finished_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_write) begin
                    tx_shift_d = tx_data;
                    tx_state_d = TX_START;
                    tx_cnt_d   = BIT_LOAD;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bits_d  = 4'd0;
                    tx_cnt_d   = BIT_LOAD;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_cnt_d = BIT_LOAD;
                    if (tx_bits_q == 4'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bits_d  = tx_bits_q + 4'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_ZERO) begin
                    tx_state_d = TX_IDLE;
                end else if (tx_cnt_q == CNT_ONE) begin
                    tx_finished_d = 1'b1;
                    tx_busy_d     = 1'b0;
                    tx_cnt_d      = tx_cnt_q - CNT_ONE;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
        dbg_tx_d = (tx_state_d != TX_IDLE);
    end

    // Transmit state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= CNT_ZERO;
            tx_bits_q     <= 4'd0;
            tx_shift_q    <= 8'h00;
            tx_q          <= 1'b1;
            tx_busy_q     <= 1'b0;
            tx_finished_q <= 1'b0;
            dbg_tx_q      <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bits_q     <= tx_bits_d;
            tx_shift_q    <= tx_shift_d;
            tx_q          <= tx_d;
            tx_busy_q     <= tx_busy_d;
            tx_finished_q <= tx_finished_d;
            dbg_tx_q      <= dbg_tx_d;
        end
    end

    assign tx                = tx_q;
    assign tx_busy           = tx_busy_q;
    assign tx_finished       = tx_finished_q;
    assign dbg_tx_inprogress = dbg_tx_q;
    assign rx_data           = rx_data_q;
    assign rx_ready          = rx_ready_q;
    assign rx_stopbit        = rx_stopbit_q;
    assign rx_frame_err      = rx_frame_err_q;
    assign dbg_rx_inprogress = dbg_rx_q;

endmodule

// File: doc/uart_trx.md
UART_TRX -- requirements
Module: uart_trx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_FREQ, default 115200, baud rate; DIV = CLK_FREQ/UART_FREQ (integer, truncated), HALF = DIV/2.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 rx  in  1  serial input, idle high, asynchronous to clk.
REQ-007 tx  out  1  serial output, idle high.
REQ-008 rx_data  out  8  last received byte, valid from rx_ready pulse until next rx_ready.
REQ-009 rx_ready  out  1  one-cycle pulse, byte received with valid stop bit.
REQ-010 rx_stopbit  out  1  one-cycle pulse when the 8th data bit is sampled (early busy hint for consumer).
REQ-011 rx_frame_err  out  1  one-cycle pulse, stop bit sampled low.
REQ-012 tx_write  in  1  one-cycle request to send tx_data.
REQ-013 tx_data  in  8  byte to send, sampled only in the tx_write cycle.
REQ-014 tx_finished  out  1  one-cycle pulse at end of stop bit.
REQ-015 tx_busy  out  1  high from cycle after accepted tx_write until tx_finished cycle (inclusive of neither edge ambiguity: low in tx_finished cycle).
REQ-016 dbg_rx_inprogress / dbg_tx_inprogress  out  1 each  high while RX / TX FSM not IDLE.

Function
REQ-017 Frame format SHALL be 8N1, LSB first: start 0, 8 data, stop 1, each bit DIV clk cycles.
REQ-018 rx SHALL pass a 2-FF synchronizer; all RX decisions use the synchronized value only.
REQ-019 RX FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-020 IDLE->START on synchronized falling edge; counter loaded HALF.
REQ-021 START: at counter expiry, line low -> DATA (counter DIV); line high -> IDLE (glitch rejected, no outputs).
REQ-022 DATA: sample every DIV cycles into shift register; after 8th sample pulse rx_stopbit and go STOP.
REQ-023 STOP: sample after DIV cycles; high -> load rx_data, pulse rx_ready same cycle, go IDLE; low -> pulse rx_frame_err, rx_data unchanged, go WAIT_IDLE.
REQ-024 WAIT_IDLE -> IDLE when synchronized line high; no new start accepted before.
REQ-025 TX FSM states SHALL be IDLE, START, DATA, STOP; tx registered output.
REQ-026 tx_write in IDLE SHALL latch tx_data; tx goes low in next cycle (latency 1).
REQ-027 tx_write while tx_busy high SHALL be ignored with no side effects.
REQ-028 tx_finished SHALL pulse in cycle 10*DIV after accepted tx_write; tx_write in that same cycle is not accepted, tx_write in the following cycle is.
REQ-029 RX and TX SHALL operate fully independently (full duplex).
REQ-030 Bit counters SHALL be 4 bits; cycle counters ceil(log2(DIV+1)) bits, counting down to 0.

Reset
REQ-031 On reset: tx=1, tx_busy=0, tx_finished=0, rx_ready=0, rx_stopbit=0, rx_frame_err=0, rx_data=8'h00, both FSMs IDLE, dbg outputs 0, synchronizer FFs=1.
REQ-032 Reset mid-frame SHALL abort both directions immediately; no rx_ready/tx_finished pulse follows.

Structure
REQ-033 RX/TX state encodings and the DIV/HALF computation SHALL live in shared package uart_pkg.
REQ-034 One sub-module sync2 (2-FF synchronizer, reset value 1) SHALL be instantiated for rx.

Verification (CLK_FREQ=12000000, UART_FREQ=115200, DIV=104)
REQ-035 Drive rx frame 0xA5 at 104 cycles/bit -> one rx_stopbit pulse, then one rx_ready ~104 cycles later with rx_data=8'hA5, rx_frame_err never high.
REQ-036 rx low pulse of 30 cycles -> START rejects, no rx_stopbit/rx_ready, dbg_rx_inprogress back to 0 within 60 cycles.
REQ-037 Frame 0x3C with stop bit 0 -> rx_frame_err pulse, no rx_ready, rx_data keeps 0xA5; line high then frame 0x55 -> rx_ready, rx_data=8'h55.
REQ-038 tx_write with 0x5A at cycle 0 -> tx low cycles 1-104, data bits 0,1,0,1,1,0,1,0, stop high, tx_finished at cycle 1040; second tx_write at cycle 500 ignored.
REQ-039 tx_write 0x01 in cycle after tx_finished -> new start bit 1 cycle later; simultaneous RX 0xFF completes with rx_data=8'hFF.
REQ-040 Assert reset during RX bit 3 and TX bit 5 -> tx=1 next cycle, all outputs at reset values, no later rx_ready/tx_finished.
